// File: rtl/sisc_mc_core_if.sv
// sisc_mc_core_if
//   Instruction handshake between the fetch unit and the SISC core.
//   ir        32-bit instruction word   (fetch -> core)
//   ir_valid  ir is valid this cycle    (fetch -> core)
//   ir_ready  core accepts ir this cycle (core -> fetch)
//   master: fetch side, slave: core side.
interface sisc_mc_core_if;
  logic [31:0] ir;
  logic        ir_valid;
  logic        ir_ready;

  modport master (output ir, output ir_valid, input ir_ready);
  modport slave  (input ir, input ir_valid, output ir_ready);
endinterface

// File: rtl/sisc_mc_core.sv
// sisc_mc_core
//   Multicycle SISC execution core. It holds the register file, the ALU, the
//   status register and the control FSM. Each accepted instruction runs through
//   DECODE, EXECUTE and WRITEBACK, and the core then returns to IDLE. HALT parks
//   the core until reset.
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   bus       instruction handshake (ir, ir_valid in; ir_ready out)
//   busy      high in DECODE, EXECUTE and WRITEBACK
//   halted    high in HALTED
//   stat      status register {C,V,N,Z}
//   illegal   one-cycle pulse in WRITEBACK of an undefined op/mm
//   dbg_addr  debug register select
//   dbg_data  combinational read of reg[dbg_addr]
module sisc_mc_core #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  sisc_mc_core_if.slave     bus,
  output logic              busy,
  output logic              halted,
  output logic [3:0]        stat,
  output logic              illegal,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int NREG = 2 ** REG_AW;
  localparam int SW   = $clog2(DATA_W);
  localparam int MSB  = DATA_W - 1;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] DECODE    = 3'd1;
  localparam logic [2:0] EXECUTE   = 3'd2;
  localparam logic [2:0] WRITEBACK = 3'd3;
  localparam logic [2:0] HALTED    = 3'd4;

  typedef logic [DATA_W-1:0] word_t;

  logic [2:0]        state_r;
  logic [2:0]        stateNext_s;
  logic              irReady_r;
  logic              busy_r;
  logic              halted_r;
  logic [31:0]       irLatch_r;
  word_t             opA_r;
  word_t             opB_r;
  word_t             result_r;
  logic [3:0]        flags_r;
  logic              aluOk_r;
  logic              illegal_r;
  logic [3:0]        stat_r;
  word_t             regFile_r [NREG];

  logic [3:0]        opField_s;
  logic [3:0]        mmField_s;
  logic [REG_AW-1:0] rdField_s;
  logic [REG_AW-1:0] rsField_s;
  logic [REG_AW-1:0] rtField_s;
  word_t             immExt_s;

  word_t             aluRes_s;
  logic              aluC_s;
  logic              aluV_s;
  logic              aluLegal_s;
  logic              illegalOp_s;
  logic [DATA_W:0]   sumWide_s;
  logic [DATA_W:0]   shlWide_s;
  logic [DATA_W:0]   shrWide_s;
  logic [SW-1:0]     shAmt_s;

  assign opField_s = irLatch_r[31:28];
  assign mmField_s = irLatch_r[27:24];
  assign rdField_s = irLatch_r[20 +: REG_AW];
  assign rsField_s = irLatch_r[16 +: REG_AW];
  assign rtField_s = irLatch_r[12 +: REG_AW];
  assign immExt_s  = word_t'($signed(irLatch_r[15:0]));

  // Undefined ops (anything other than NOP, the two ALU forms and HALT) or undefined mm.
  assign illegalOp_s = (opField_s != 4'h0) && !aluLegal_s;

  assign bus.ir_ready = irReady_r;
  assign busy         = busy_r;
  assign halted       = halted_r;
  assign stat         = stat_r;
  assign illegal      = illegal_r;
  assign dbg_data     = regFile_r[dbg_addr];

  // Next-state logic of the control FSM.
  always_comb begin
    stateNext_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.ir_valid) begin
          stateNext_s = DECODE;
        end else begin
          stateNext_s = IDLE;
        end
      end
      DECODE: begin
        if (opField_s == 4'hF) begin
          stateNext_s = HALTED;
        end else begin
          stateNext_s = EXECUTE;
        end
      end
      EXECUTE:   stateNext_s = WRITEBACK;
      WRITEBACK: stateNext_s = IDLE;
      HALTED:    stateNext_s = HALTED;
      default:   stateNext_s = IDLE;
    endcase
  end

  // ALU: result and flags from the operand latches.
  always_comb begin
    aluRes_s   = {DATA_W{1'b0}};
    aluC_s     = 1'b0;
    aluV_s     = 1'b0;
    aluLegal_s = 1'b0;
    sumWide_s  = {(DATA_W + 1){1'b0}};
    shlWide_s  = {(DATA_W + 1){1'b0}};
    shrWide_s  = {(DATA_W + 1){1'b0}};
    shAmt_s    = opB_r[SW-1:0];
    if ((opField_s == 4'h1) || (opField_s == 4'h2)) begin
      case (mmField_s)
        4'h1: begin
          sumWide_s  = {1'b0, opA_r} + {1'b0, opB_r};
          aluRes_s   = sumWide_s[DATA_W-1:0];
          aluC_s     = sumWide_s[DATA_W];
          aluV_s     = (opA_r[MSB] == opB_r[MSB]) && (aluRes_s[MSB] != opA_r[MSB]);
          aluLegal_s = 1'b1;
        end
        4'h2: begin
          // Subtract as A + ~B + 1 so the carry out means "no borrow".
          sumWide_s  = {1'b0, opA_r} + {1'b0, ~opB_r} + {{DATA_W{1'b0}}, 1'b1};
          aluRes_s   = sumWide_s[DATA_W-1:0];
          aluC_s     = sumWide_s[DATA_W];
          aluV_s     = (opA_r[MSB] != opB_r[MSB]) && (aluRes_s[MSB] != opA_r[MSB]);
          aluLegal_s = 1'b1;
        end
        4'h3: begin
          aluRes_s   = opA_r & opB_r;
          aluLegal_s = 1'b1;
        end
        4'h4: begin
          aluRes_s   = opA_r | opB_r;
          aluLegal_s = 1'b1;
        end
        4'h5: begin
          aluRes_s   = opA_r ^ opB_r;
          aluLegal_s = 1'b1;
        end
        4'h6: begin
          aluRes_s   = ~opA_r;
          aluLegal_s = 1'b1;
        end
        4'h7: begin
          // One extra bit on top catches the last bit shifted out (0 when s==0).
          shlWide_s  = {1'b0, opA_r} << shAmt_s;
          aluRes_s   = shlWide_s[DATA_W-1:0];
          aluC_s     = shlWide_s[DATA_W];
          aluLegal_s = 1'b1;
        end
        4'h8: begin
          // One extra bit below catches the last bit shifted out (0 when s==0).
          shrWide_s  = {opA_r, 1'b0} >> shAmt_s;
          aluRes_s   = shrWide_s[DATA_W:1];
          aluC_s     = shrWide_s[0];
          aluLegal_s = 1'b1;
        end
        default: aluLegal_s = 1'b0;
      endcase
    end else begin
      aluLegal_s = 1'b0;
    end
  end

  // FSM state and the status outputs, which are registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      irReady_r <= 1'b1;
      busy_r    <= 1'b0;
      halted_r  <= 1'b0;
    end else begin
      state_r   <= stateNext_s;
      irReady_r <= (stateNext_s == IDLE);
      busy_r    <= (stateNext_s == DECODE) || (stateNext_s == EXECUTE) ||
                   (stateNext_s == WRITEBACK);
      halted_r  <= (stateNext_s == HALTED);
    end
  end

  // Pipeline latches: instruction, operands, ALU result/flags, illegal pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irLatch_r <= 32'h0000_0000;
      opA_r     <= {DATA_W{1'b0}};
      opB_r     <= {DATA_W{1'b0}};
      result_r  <= {DATA_W{1'b0}};
      flags_r   <= 4'h0;
      aluOk_r   <= 1'b0;
      illegal_r <= 1'b0;
    end else begin
      if ((state_r == IDLE) && bus.ir_valid) begin
        irLatch_r <= bus.ir;
      end
      // Operands are sampled here, so rd may equal rs/rt without a hazard.
      if (state_r == DECODE) begin
        opA_r <= regFile_r[rsField_s];
        opB_r <= (opField_s == 4'h2) ? immExt_s : regFile_r[rtField_s];
      end
      if (state_r == EXECUTE) begin
        result_r <= aluRes_s;
        flags_r  <= {aluC_s, aluV_s, aluRes_s[MSB], (aluRes_s == {DATA_W{1'b0}})};
        aluOk_r  <= aluLegal_s;
      end
      // High for exactly the WRITEBACK cycle that follows an illegal EXECUTE.
      illegal_r <= (state_r == EXECUTE) && illegalOp_s;
    end
  end

  // Register file commit; register 0 is never written so it always reads 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regFile_r[i] <= {DATA_W{1'b0}};
      end
    end else if ((state_r == WRITEBACK) && aluOk_r && (rdField_s != {REG_AW{1'b0}})) begin
      regFile_r[rdField_s] <= result_r;
    end
  end

  // Status register commit on legal ALU ops only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_r <= 4'h0;
    end else if ((state_r == WRITEBACK) && aluOk_r) begin
      stat_r <= flags_r;
    end
  end

endmodule

// File: tb/tb_sisc_mc_core.sv
module tb_sisc_mc_core;

  typedef struct {
    logic [3:0]  rd;
    logic [31:0] val;
    logic [3:0]  stat;
    logic        ill;
    int          acc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] irDrv;
  logic        irValid;
  logic        busy;
  logic        halted;
  logic [3:0]  stat;
  logic        illegal;
  logic [3:0]  dbgAddr;
  logic [31:0] dbgData;

  int          cyc = 0;
  int          passCnt = 0;
  int          totalCnt = 0;
  int          sweepReq = 0;
  int          sweepDone = 0;
  exp_t        expQ[$];
  logic [31:0] mReg [16];
  logic [3:0]  mStat;

  sisc_mc_core_if bus ();
  assign bus.ir       = irDrv;
  assign bus.ir_valid = irValid;

  sisc_mc_core #(.DATA_W(32), .REG_AW(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .busy    (busy),
    .halted  (halted),
    .stat    (stat),
    .illegal (illegal),
    .dbg_addr(dbgAddr),
    .dbg_data(dbgData)
  );

  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    totalCnt++;
    if (act === req) passCnt++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference model: executes an instruction on the architectural state and
  // queues what the core must show when it completes.
  task automatic modelStep(input logic [31:0] instr, input int accCyc);
    exp_t        e;
    logic [3:0]  op, mm, rd, rs, rt;
    logic [31:0] a, b, r;
    logic        c, v, legal;
    longint      sr;
    int          s;
    op = instr[31:28]; mm = instr[27:24]; rd = instr[23:20];
    rs = instr[19:16]; rt = instr[15:12];
    a = mReg[rs];
    b = (op == 4'h2) ? {{16{instr[15]}}, instr[15:0]} : mReg[rt];
    s = int'(b[4:0]);
    r = 32'h0; c = 1'b0; v = 1'b0; sr = 0;
    legal = ((op == 4'h1) || (op == 4'h2)) && (mm >= 4'h1) && (mm <= 4'h8);
    case (mm)
      4'h1: begin
        r  = a + b;
        c  = (longint'(a) + longint'(b)) > 64'sd4294967295;
        sr = longint'($signed(a)) + longint'($signed(b));
        v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      4'h2: begin
        r  = a - b;
        c  = (a >= b);
        sr = longint'($signed(a)) - longint'($signed(b));
        v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      4'h3: r = a & b;
      4'h4: r = a | b;
      4'h5: r = a ^ b;
      4'h6: r = ~a;
      4'h7: begin r = a << s; c = (s == 0) ? 1'b0 : a[32 - s]; end
      4'h8: begin r = a >> s; c = (s == 0) ? 1'b0 : a[s - 1]; end
      default: r = 32'h0;
    endcase
    if (legal) begin
      if (rd != 4'h0) mReg[rd] = r;
      mStat = {c, v, r[31], (r == 32'h0)};
    end
    e.rd   = rd;
    e.val  = (rd == 4'h0) ? 32'h0 : mReg[rd];
    e.stat = mStat;
    e.ill  = !((op == 4'h0) || legal);
    e.acc  = accCyc;
    expQ.push_back(e);
  endtask

  task automatic modelReset();
    for (int i = 0; i < 16; i++) mReg[i] = 32'h0;
    mStat = 4'h0;
  endtask

  // Monitor: pops the scoreboard whenever an instruction completes, and serves sweep requests.
  initial begin
    exp_t e;
    logic prevBusy;
    int   illCnt;
    prevBusy = 1'b0; illCnt = 0; dbgAddr = 4'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prevBusy = 1'b0; illCnt = 0;
      end else begin
        if (illegal) illCnt++;
        if (prevBusy && !busy && bus.ir_ready) begin
          if (expQ.size() == 0) begin
            check("unexpected_commit", 32'd1, 32'd0);
          end else begin
            e = expQ.pop_front();
            dbgAddr = e.rd;
            #1;
            check("rd_value", dbgData, e.val);
            check("stat", 32'(stat), 32'(e.stat));
            check("illegal_pulses", 32'(illCnt), 32'(e.ill));
            check("latency", 32'(cyc - e.acc), 32'd3);
            illCnt = 0;
          end
        end
        prevBusy = busy;
      end
      if (sweepDone != sweepReq) begin
        for (int i = 0; i < 16; i++) begin
          dbgAddr = 4'(i);
          #1;
          check("sweep_reg", dbgData, mReg[i]);
        end
        sweepDone++;
      end
    end
  end

  task automatic doSweep();
    int g;
    sweepReq++;
    g = 0;
    while ((sweepDone != sweepReq) && (g < 10)) begin @(negedge clk); g++; end
    if (sweepDone != sweepReq) check("sweep_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitReady(output bit ok);
    int g;
    g = 0;
    while (!bus.ir_ready && (g < 20)) begin @(negedge clk); g++; end
    ok = bus.ir_ready;
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue(input logic [31:0] instr, input bit junk);
    bit ok;
    @(negedge clk);
    irDrv = instr; irValid = 1'b1;
    waitReady(ok);
    if (!ok) begin irValid = 1'b0; return; end
    modelStep(instr, cyc + 1);
    @(posedge clk); #1;
    irValid = junk;
    for (int k = 0; k < 3; k++) begin
      irDrv = $urandom;
      @(negedge clk);
      if (junk) check("ready_while_busy", 32'(bus.ir_ready), 32'd0);
    end
    @(posedge clk); #1;
    irValid = 1'b0;
    if (junk) begin
      @(negedge clk);
      check("ready_after_wb", 32'(bus.ir_ready), 32'd1);
    end
  endtask

  function automatic logic [31:0] randInstr();
    logic [3:0] op, mm;
    int p;
    p = $urandom_range(0, 99);
    if (p < 5)       op = 4'h0;
    else if (p < 10) op = 4'($urandom_range(3, 14));
    else if (p < 50) op = 4'h1;
    else             op = 4'h2;
    p = $urandom_range(0, 99);
    mm = (p < 90) ? 4'($urandom_range(1, 8)) : 4'($urandom_range(9, 16));
    return {op, mm, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 16'($urandom)};
  endfunction

  task automatic finishRun();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  endtask

  initial begin
    #2000000;
    check("watchdog", 32'd0, 32'd1);
    finishRun();
  end

  initial begin
    bit ok;
    int g;
    rst = 1'b1; irValid = 1'b0; irDrv = 32'h0;
    modelReset();
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.ir_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_stat", 32'(stat), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    rst = 1'b0;
    doSweep();

    // Directed sequences
    issue(32'h21100005, 1'b0);
    issue(32'h2120FFFF, 1'b0);
    issue(32'h12311000, 1'b0);
    issue(32'h2140FFFF, 1'b0);
    issue(32'h28440001, 1'b0);
    issue(32'h21440001, 1'b0);
    issue(32'h25510003, 1'b1);
    issue(32'h21000007, 1'b0);
    issue(32'h1F000000, 1'b0);
    issue(32'h00000000, 1'b0);
    issue(32'h27620004, 1'b0);
    issue(32'h28740021, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 200; n++) issue(randInstr(), ($urandom_range(0, 9) == 0));

    g = 0;
    while ((expQ.size() != 0) && (g < 20)) begin @(negedge clk); g++; end
    check("drain", 32'(expQ.size()), 32'd0);
    doSweep();

    // Reset in EXECUTE aborts the instruction
    @(negedge clk);
    irDrv = 32'h21500009; irValid = 1'b1;
    waitReady(ok);
    @(posedge clk); #1;
    irValid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready", 32'(bus.ir_ready), 32'd1);
    check("abort_stat", 32'(stat), 32'd0);
    modelReset();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    doSweep();

    // HALT parks the core until reset
    issue(32'h21600003, 1'b0);
    @(negedge clk);
    irDrv = 32'hF0000000; irValid = 1'b1;
    waitReady(ok);
    @(posedge clk); #1;
    irDrv = 32'h21600001;
    @(negedge clk);
    check("halt_decode_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("halted", 32'(halted), 32'd1);
    check("halted_busy", 32'(busy), 32'd0);
    repeat (8) @(negedge clk);
    check("halted_hold", 32'(halted), 32'd1);
    check("halted_ready", 32'(bus.ir_ready), 32'd0);
    irValid = 1'b0;
    doSweep();
    check("halted_stat", 32'(stat), 32'(mStat));
    rst = 1'b1;
    #1;
    check("unhalt", 32'(halted), 32'd0);
    check("unhalt_ready", 32'(bus.ir_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    finishRun();
  end

endmodule
